// File: rtl/huffman_merge_if.sv
// huffman_merge_if: the Huffman merge block's leaf input, sorter handshake and code output bundle.
// slave is the merge block; master is whoever feeds leaves and hosts the sorter/packer.
interface huffman_merge_if;
  logic        start;
  logic [12:0] leaf0, leaf1, leaf2, leaf3, leaf4;
  logic        sort_begin;
  logic [12:0] node0, node1, node2, node3, node4;
  logic [12:0] new1, new2, new3, new4, new5;
  logic        sort_over;
  logic        code_valid;
  logic [4:0]  code_sym;
  logic [3:0]  code_bits;
  logic [2:0]  code_len;
  logic [7:0]  root_weight;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  start, leaf0, leaf1, leaf2, leaf3, leaf4,
    input  new1, new2, new3, new4, new5, sort_over,
    output sort_begin, node0, node1, node2, node3, node4,
    output code_valid, code_sym, code_bits, code_len, root_weight, busy, done, err
  );

  modport master (
    output start, leaf0, leaf1, leaf2, leaf3, leaf4,
    output new1, new2, new3, new4, new5, sort_over,
    input  sort_begin, node0, node1, node2, node3, node4,
    input  code_valid, code_sym, code_bits, code_len, root_weight, busy, done, err
  );
endinterface

// File: rtl/huffman_merge.sv
// huffman_merge: builds a 5-leaf Huffman tree using an external 5-entry sorter
// (four sort/merge rounds), then walks the tree and emits one code per leaf.
// Optional: define HUFF_MERGE_TMO_EN to enable the sort-wait watchdog (err pulse).
module huffman_merge #(
  parameter int SORT_LAT = 3,
  parameter int TMO_CYC  = 255
) (
  input logic            CLK,
  input logic            nRST,
  huffman_merge_if.slave bus
);
  typedef struct packed {
    logic [7:0] w;
    logic [4:0] id;
  } node_t;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, MERGE, WALK, EMIT, FIN} state_t;

  localparam node_t      SENT = 13'h1FFF;
  localparam logic [3:0] ROOT = 4'd8;
`ifdef HUFF_MERGE_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_t      state, nxt;
  node_t       nodes   [5];
  node_t       srt     [5];
  node_t       leaf_in [5];
  node_t       new_in  [5];
  logic [3:0]  par     [9];
  logic [8:0]  bt;
  logic [15:0] cnt;
  logic [1:0]  round;
  logic [2:0]  leaf;
  logic [3:0]  cur;
  logic [3:0]  wcode, wnext;
  logic [2:0]  wlen;
  logic        wlast, accept, tmo;
  logic [8:0]  sum;
  logic [7:0]  mw;
  logic [3:0]  nid;
  logic [4:0]  sym_q;
  logic [3:0]  bits_q;
  logic [2:0]  len_q;
  logic [7:0]  root_q;

  function automatic node_t clamp(node_t n);
    node_t r = n;
    if (r.w == 8'hFF) r.w = 8'hFE;
    return r;
  endfunction

  assign leaf_in[0] = bus.leaf0;
  assign leaf_in[1] = bus.leaf1;
  assign leaf_in[2] = bus.leaf2;
  assign leaf_in[3] = bus.leaf3;
  assign leaf_in[4] = bus.leaf4;
  assign new_in[0]  = bus.new1;
  assign new_in[1]  = bus.new2;
  assign new_in[2]  = bus.new3;
  assign new_in[3]  = bus.new4;
  assign new_in[4]  = bus.new5;

  assign bus.node0       = nodes[0];
  assign bus.node1       = nodes[1];
  assign bus.node2       = nodes[2];
  assign bus.node3       = nodes[3];
  assign bus.node4       = nodes[4];
  assign bus.code_sym    = sym_q;
  assign bus.code_bits   = bits_q;
  assign bus.code_len    = len_q;
  assign bus.root_weight = root_q;

  // cnt holds cycles elapsed since sort_begin (1 in the first WAIT cycle)
  assign accept = (state == WAIT) && bus.sort_over && (cnt >= 16'(SORT_LAT));
  assign tmo    = TMO_EN && (state == WAIT) && !accept && (cnt >= 16'(TMO_CYC));

  // merge of the two smallest returned entries, saturating below the sentinel weight
  assign sum = {1'b0, srt[0].w} + {1'b0, srt[1].w};
  assign mw  = (sum > 9'd254) ? 8'hFE : sum[7:0];
  assign nid = 4'd5 + {2'b00, round};

  // one tree level per WALK cycle; the depth cap keeps a corrupt table from looping
  assign wnext = wcode | ({3'b000, bt[cur]} << wlen[1:0]);
  assign wlast = (par[cur] == ROOT) || (wlen == 3'd3);

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= nxt;
  end

  // next-state and strobe outputs
  always_comb begin
    nxt            = state;
    bus.sort_begin = 1'b0;
    bus.code_valid = 1'b0;
    bus.done       = 1'b0;
    bus.busy       = (state != IDLE);
    bus.err        = tmo;
    case (state)
      IDLE:  if (bus.start) nxt = SEND;
      SEND:  begin bus.sort_begin = 1'b1; nxt = WAIT; end
      WAIT:  if (accept) nxt = MERGE; else if (tmo) nxt = IDLE;
      MERGE: nxt = (round == 2'd3) ? WALK : SEND;
      WALK:  if (wlast) nxt = EMIT;
      EMIT:  begin bus.code_valid = 1'b1; nxt = (leaf == 3'd4) ? FIN : WALK; end
      FIN:   begin bus.done = 1'b1; nxt = IDLE; end
      default: nxt = IDLE;
    endcase
  end

  // node list, tree tables, walk cursor and held code outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 5; i++) begin
        nodes[i] <= '0;
        srt[i]   <= '0;
      end
      for (int j = 0; j < 9; j++) par[j] <= '0;
      bt     <= '0;
      cnt    <= '0;
      round  <= '0;
      leaf   <= '0;
      cur    <= '0;
      wcode  <= '0;
      wlen   <= '0;
      sym_q  <= '0;
      bits_q <= '0;
      len_q  <= '0;
      root_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          for (int i = 0; i < 5; i++) nodes[i] <= clamp(leaf_in[i]);
          round <= '0;
        end
        SEND: cnt <= 16'd1;
        WAIT: begin
          if (cnt != '1) cnt <= cnt + 16'd1;
          if (accept) for (int i = 0; i < 5; i++) srt[i] <= new_in[i];
          if (tmo) begin
            for (int j = 0; j < 9; j++) par[j] <= '0;
            bt <= '0;
          end
        end
        MERGE: begin
          for (int j = 0; j < 9; j++) begin
            if (srt[0].id == 5'(j)) begin par[j] <= nid; bt[j] <= 1'b0; end
            if (srt[1].id == 5'(j)) begin par[j] <= nid; bt[j] <= 1'b1; end
          end
          nodes[0] <= {mw, 1'b0, nid};
          nodes[1] <= srt[2];
          nodes[2] <= srt[3];
          nodes[3] <= srt[4];
          nodes[4] <= SENT;
          round    <= round + 2'd1;
          if (round == 2'd3) begin
            root_q <= mw;
            leaf   <= '0;
            cur    <= '0;
            wcode  <= '0;
            wlen   <= '0;
          end
        end
        WALK: begin
          wcode <= wnext;
          wlen  <= wlen + 3'd1;
          cur   <= par[cur];
          if (wlast) begin
            sym_q  <= {2'b00, leaf};
            bits_q <= wnext;
            len_q  <= wlen + 3'd1;
          end
        end
        EMIT: begin
          leaf  <= leaf + 3'd1;
          cur   <= {1'b0, leaf} + 4'd1;
          wcode <= '0;
          wlen  <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_merge.sv
// tb_huffman_merge: table vectors, random leaves against a merge-list model,
// sticky handshake, busy/start, mid-run reset and (with HUFF_MERGE_TMO_EN) watchdog.
module tb_huffman_merge;
  localparam int TMO = 20;
  typedef logic [4:0][12:0] list_t;
  typedef struct packed {
    list_t            lv;
    logic [4:0][3:0]  eb;
    logic [4:0][2:0]  el;
    logic [7:0]       er;
  } vec_t;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;
  int   so_mode = 0;  // 0: delayed pulse-ish, 1: sticky high, 2: never
  vec_t tbl [4];

  huffman_merge_if bif ();
  huffman_merge #(.SORT_LAT(3), .TMO_CYC(TMO)) dut (.CLK(CLK), .nRST(nRST), .bus(bif.slave));

  always #5 CLK = ~CLK;

  function automatic logic [12:0] lf(int w, int id);
    return {8'(w), 5'(id)};
  endfunction

  // stable ascending sort by weight
  function automatic list_t sort5(list_t x);
    logic [12:0] t;
    for (int i = 1; i < 5; i++)
      for (int j = i; j > 0; j--)
        if (x[j-1][12:5] > x[j][12:5]) begin t = x[j]; x[j] = x[j-1]; x[j-1] = t; end
    return x;
  endfunction

  function automatic list_t clampl(list_t x);
    for (int i = 0; i < 5; i++) if (x[i][12:5] == 8'hFF) x[i][12:5] = 8'hFE;
    return x;
  endfunction

  // Huffman reference: each node carries the set of leaves beneath it; a merge
  // appends one more (higher) code bit to every leaf in each merged set.
  function automatic void model(input list_t lv, output logic [4:0][3:0] eb,
                                output logic [4:0][2:0] el, output logic [7:0] er);
    list_t L, nx;
    logic [4:0] m [32];
    logic [4:0] ma, mb;
    int w;
    L = clampl(lv); eb = '0; el = '0; er = '0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    for (int i = 0; i < 5; i++) m[i] = 5'(1 << i);
    for (int r = 0; r < 4; r++) begin
      L  = sort5(L);
      ma = m[L[0][4:0]];
      mb = m[L[1][4:0]];
      for (int k = 0; k < 5; k++) begin
        if (ma[k]) el[k] = 3'(el[k] + 1);
        if (mb[k]) begin eb[k] = eb[k] | (4'd1 << el[k]); el[k] = 3'(el[k] + 1); end
      end
      w = int'(L[0][12:5]) + int'(L[1][12:5]);
      if (w > 254) w = 254;
      m[5+r] = ma | mb;
      nx[0] = {8'(w), 5'(5 + r)}; nx[1] = L[2]; nx[2] = L[3]; nx[3] = L[4]; nx[4] = 13'h1FFF;
      L  = nx;
      er = 8'(w);
    end
  endfunction

  function automatic logic [95:0] outs();
    return {6'b0, bif.sort_begin, bif.node4, bif.node3, bif.node2, bif.node1, bif.node0,
            bif.code_valid, bif.code_sym, bif.code_bits, bif.code_len, bif.root_weight,
            bif.busy, bif.done, bif.err};
  endfunction

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic set_leaves(input list_t lv);
    bif.leaf0 = lv[0]; bif.leaf1 = lv[1]; bif.leaf2 = lv[2]; bif.leaf3 = lv[3]; bif.leaf4 = lv[4];
  endtask

  // behavioural sorter: captures the list on sort_begin, answers with a stable sort
  initial begin : sorter
    list_t s;
    int    dly = 0;
    bit    armed = 0;
    bif.sort_over = 1'b0;
    bif.new1 = '0; bif.new2 = '0; bif.new3 = '0; bif.new4 = '0; bif.new5 = '0;
    forever begin
      @(negedge CLK);
      if (bif.sort_begin) begin
        s = sort5({bif.node4, bif.node3, bif.node2, bif.node1, bif.node0});
        bif.new1 = s[0]; bif.new2 = s[1]; bif.new3 = s[2]; bif.new4 = s[3]; bif.new5 = s[4];
        if (so_mode == 0) begin bif.sort_over = 1'b0; dly = $urandom_range(0, 4); armed = 1; end
      end else if (armed) begin
        if (dly == 0) begin bif.sort_over = 1'b1; armed = 0; end
        else dly--;
      end
      if (so_mode == 1) begin bif.sort_over = 1'b1; armed = 0; end
      if (so_mode == 2) begin bif.sort_over = 1'b0; armed = 0; end
    end
  end

  // one full tree build; repulse>0 re-pulses start (with other leaves) that many cycles in
  task automatic run(input list_t lv, input logic [4:0][3:0] eb, input logic [4:0][2:0] el,
                     input logic [7:0] er, input string tag, input int repulse, input int exp_cyc);
    int sb = 0, cv = 0, nd = 0, ne = 0, cyc = 0, post = -1, ns;
    logic [4:0][4:0] gs = '0;
    logic [4:0][3:0] gb = '0;
    logic [4:0][2:0] gl = '0;
    list_t nl;
    @(negedge CLK);
    set_leaves(lv);
    bif.start = 1'b1;
    for (int i = 0; i < 4000 && post != 0; i++) begin
      @(negedge CLK);
      if (i == 0) bif.start = 1'b0;
      if (repulse > 0 && i == repulse) begin
        bif.start = 1'b1;
        set_leaves({lf(3, 4), lf(3, 3), lf(3, 2), lf(3, 1), lf(3, 0)});
      end
      if (repulse > 0 && i == repulse + 1) bif.start = 1'b0;
      if (bif.sort_begin) begin
        nl = {bif.node4, bif.node3, bif.node2, bif.node1, bif.node0};
        ns = 0;
        for (int k = 0; k < 5; k++) if (nl[k] == 13'h1FFF) ns++;
        chk({tag, ".sentinels"}, ns, sb);
        if (sb == 0) chk({tag, ".list0"}, nl, clampl(lv));
        sb++;
      end
      if (bif.code_valid) begin
        if (cv < 5) begin gs[cv] = bif.code_sym; gb[cv] = bif.code_bits; gl[cv] = bif.code_len; end
        cv++;
      end
      if (bif.done) nd++;
      if (bif.err) ne++;
      if (bif.busy && !bif.done && nd == 0) cyc++;
      if (post > 0) post--;
      else if (post < 0 && (bif.done || bif.err)) post = 4;
    end
    chk({tag, ".finished"}, post == 0, 1);
    chk({tag, ".sort_begins"}, sb, 4);
    chk({tag, ".code_valids"}, cv, 5);
    chk({tag, ".dones"}, nd, 1);
    chk({tag, ".errs"}, ne, 0);
    chk({tag, ".root"}, bif.root_weight, er);
    chk({tag, ".idle"}, bif.busy, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s.sym%0d", tag, k), gs[k], k);
      chk($sformatf("%s.bits%0d", tag, k), gb[k], eb[k]);
      chk($sformatf("%s.len%0d", tag, k), gl[k], el[k]);
    end
    if (exp_cyc > 0) chk({tag, ".cycles"}, cyc, exp_cyc);
  endtask

  // reset asserted in the WAIT of round 2 must zero every output at once
  task automatic reset_mid();
    int sb = 0;
    bit found = 0;
    so_mode = 1;
    @(negedge CLK);
    set_leaves(tbl[3].lv);
    bif.start = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK);
      if (i == 0) bif.start = 1'b0;
      if (bif.sort_begin) sb++;
      else if (sb == 3) found = 1;
    end
    chk("rstmid.reached", found, 1);
    nRST = 1'b0;
    #1;
    chk("rstmid.outs", outs(), '0);
    @(negedge CLK);
    nRST = 1'b1;
    run(tbl[3].lv, tbl[3].eb, tbl[3].el, tbl[3].er, "post_rst", 0, 0);
  endtask

`ifdef HUFF_MERGE_TMO_EN
  // sorter never answers: err must land TMO cycles into WAIT, then idle, no done
  task automatic wdog();
    int k = 0, gap = -1, nd = 0;
    bit seen = 0;
    so_mode = 2;
    @(negedge CLK);
    set_leaves(tbl[0].lv);
    bif.start = 1'b1;
    for (int i = 0; i < 3 * TMO + 10 && gap < 0; i++) begin
      @(negedge CLK);
      if (i == 0) bif.start = 1'b0;
      if (bif.done) nd++;
      if (seen) begin k++; if (bif.err) gap = k; end
      else if (bif.sort_begin) seen = 1;
    end
    chk("wdog.gap", gap, TMO);
    @(negedge CLK);
    chk("wdog.busy", bif.busy, 0);
    repeat (5) begin @(negedge CLK); if (bif.done) nd++; end
    chk("wdog.dones", nd, 0);
    so_mode = 0;
  endtask
`endif

  initial begin
    list_t lv;
    logic [4:0][3:0] eb;
    logic [4:0][2:0] el;
    logic [7:0] er;

    tbl[0] = '{lv: {lf(16, 4), lf(8, 3), lf(4, 2), lf(2, 1), lf(1, 0)},
               eb: {4'h1, 4'h1, 4'h1, 4'h1, 4'h0}, el: {3'd1, 3'd2, 3'd3, 3'd4, 3'd4}, er: 8'd31};
    tbl[1] = '{lv: {lf(200, 4), lf(200, 3), lf(200, 2), lf(200, 1), lf(200, 0)},
               eb: {4'h0, 4'h3, 4'h2, 4'h3, 4'h2}, el: {3'd2, 3'd3, 3'd3, 3'd2, 3'd2}, er: 8'hFE};
    tbl[2] = '{lv: {lf(1, 4), lf(1, 3), lf(1, 2), lf(1, 1), lf(255, 0)},
               eb: {4'h1, 4'h0, 4'h3, 4'h2, 4'h1}, el: {3'd3, 3'd3, 3'd3, 3'd3, 3'd1}, er: 8'hFE};
    tbl[3] = '{lv: {lf(16, 4), lf(13, 3), lf(12, 2), lf(9, 1), lf(5, 0)},
               eb: {4'h3, 4'h1, 4'h0, 4'h5, 4'h4}, el: {3'd2, 3'd2, 3'd2, 3'd3, 3'd3}, er: 8'd55};

    bif.start = 1'b0;
    set_leaves('0);
    repeat (2) @(negedge CLK);
    chk("reset.outs", outs(), '0);
    nRST = 1'b1;

    so_mode = 0;
    for (int i = 0; i < 4; i++)
      run(tbl[i].lv, tbl[i].eb, tbl[i].el, tbl[i].er, $sformatf("tbl%0d", i), 0, 0);

    // sticky sort_over: every round still spends SORT_LAT cycles in WAIT
    so_mode = 1;
    run(tbl[0].lv, tbl[0].eb, tbl[0].el, tbl[0].er, "sticky", 0, 39);
    run(tbl[1].lv, tbl[1].eb, tbl[1].el, tbl[1].er, "repulse", 8, 0);

    reset_mid();

    so_mode = 0;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 5; i++) begin
        case ($urandom_range(0, 7))
          0:       lv[i] = lf(255, i);
          1:       lv[i] = lf(0, i);
          2:       lv[i] = lf($urandom_range(0, 3), i);
          default: lv[i] = lf($urandom_range(0, 255), i);
        endcase
      end
      model(lv, eb, el, er);
      run(lv, eb, el, er, $sformatf("rnd%0d", n), 0, 0);
    end

`ifdef HUFF_MERGE_TMO_EN
    wdog();
    run(tbl[3].lv, tbl[3].eb, tbl[3].el, tbl[3].er, "post_wdog", 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
